// File: rtl/general_ff_reg.sv
// rtl/general_ff_reg.sv - WIDTH-bit register, each bit a run-time selectable D/T/JK/SR flip-flop
// Optional registered even parity output enabled by GENERAL_FF_REG_PARITY_EN.
module general_ff_reg #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
`ifdef GENERAL_FF_REG_PARITY_EN
    output logic             par,
`endif
    output logic             err,
    output logic             chg
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    logic [WIDTH-1:0] ff_next;
    logic [WIDTH-1:0] q_next;
    logic             sr_conflict;
    logic             err_next;

    // JK: set where j & ~q, keep where ~k & q. SR: illegal bits (s & r) keep q.
    always_comb begin
        ff_next = q;
        case (mode)
            MODE_D:  ff_next = a;
            MODE_T:  ff_next = q ^ a;
            MODE_JK: ff_next = (a & ~q) | (~b & q);
            MODE_SR: ff_next = (a & ~b) | (q & ~(a ^ b));
            default: ff_next = q;
        endcase
    end

    always_comb begin
        q_next      = q;
        sr_conflict = 1'b0;
        err_next    = err;
        if (clr) begin
            q_next   = RST_VAL;
            err_next = 1'b0;
        end else if (en) begin
            q_next      = ff_next;
            sr_conflict = (mode == MODE_SR) && (|(a & b));
            err_next    = err | sr_conflict;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q   <= RST_VAL;
            err <= 1'b0;
            chg <= 1'b0;
        end else begin
            q   <= q_next;
            err <= err_next;
            chg <= (q_next != q);
        end
    end

`ifdef GENERAL_FF_REG_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par <= ^RST_VAL;
        end else begin
            par <= ^q_next;
        end
    end
`endif

    assign qbar = ~q;

endmodule

// File: tb/tb_general_ff_reg.sv
// tb/tb_general_ff_reg.sv - directed and random checks of general_ff_reg against per-bit flip-flop models
module tb_general_ff_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         err;
    logic         chg;
`ifdef GENERAL_FF_REG_PARITY_EN
    logic         par;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq   = '0;
    logic         merr = 1'b0;
    logic         mchg = 1'b0;

    general_ff_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .clr  (clr),
        .mode (mode),
        .a    (a),
        .b    (b),
        .q    (q),
        .qbar (qbar),
`ifdef GENERAL_FF_REG_PARITY_EN
        .par  (par),
`endif
        .err  (err),
        .chg  (chg)
    );

    always #5 clk = ~clk;

    // Single-bit golden flip-flops written as truth tables.
    function automatic logic golden_bit(input logic [1:0] m, input logic qi, input logic ai, input logic bi);
        logic r;
        r = qi;
        case (m)
            2'd0: r = ai;
            2'd1: r = ai ? ~qi : qi;
            2'd2: case ({ai, bi})
                      2'b00: r = qi;
                      2'b01: r = 1'b0;
                      2'b10: r = 1'b1;
                      default: r = ~qi;
                  endcase
            default: case ({ai, bi})
                      2'b00: r = qi;
                      2'b01: r = 1'b0;
                      2'b10: r = 1'b1;
                      default: r = qi;
                  endcase
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq   = 8'h00;
        merr = 1'b0;
        mchg = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_q"},    {24'd0, q},    {24'd0, mq});
        check({tag, "_qbar"}, {24'd0, qbar}, {24'd0, ~mq});
        check({tag, "_err"},  {31'd0, err},  {31'd0, merr});
        check({tag, "_chg"},  {31'd0, chg},  {31'd0, mchg});
`ifdef GENERAL_FF_REG_PARITY_EN
        check({tag, "_par"},  {31'd0, par},  {31'd0, ^mq});
`endif
    endtask

    task automatic step(input string tag, input logic s_en, input logic s_clr,
                        input logic [1:0] s_mode, input logic [W-1:0] s_a, input logic [W-1:0] s_b);
        logic [W-1:0] nq;
        logic         conflict;
        @(negedge clk);
        en = s_en; clr = s_clr; mode = s_mode; a = s_a; b = s_b;
        nq = mq;
        conflict = 1'b0;
        if (s_clr) begin
            nq   = 8'h00;
            merr = 1'b0;
        end else if (s_en) begin
            for (int i = 0; i < W; i++) begin
                nq[i] = golden_bit(s_mode, mq[i], s_a[i], s_b[i]);
                if (s_mode == 2'd3 && s_a[i] && s_b[i]) conflict = 1'b1;
            end
            merr = merr | conflict;
        end
        mchg = (nq != mq);
        mq   = nq;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_all("reset");
        check("reset_q_const", {24'd0, q}, 32'h00);
        check("reset_qbar_const", {24'd0, qbar}, 32'hFF);

        step("d_load", 1, 0, 2'd0, 8'hA5, 8'h00);
        check("d_load_const", {24'd0, q}, 32'hA5);
        step("t_0f", 1, 0, 2'd1, 8'h0F, 8'h00);
        check("t_0f_const", {24'd0, q}, 32'hAA);
        step("t_00", 1, 0, 2'd1, 8'h00, 8'hFF);
        check("t_00_chg", {31'd0, chg}, 32'd0);

        step("jk_pre", 1, 0, 2'd0, 8'hF0, 8'h00);
        step("jk", 1, 0, 2'd2, 8'h0C, 8'h30);
        check("jk_const", {24'd0, q}, 32'hCC);

        step("sr_pre", 1, 0, 2'd0, 8'h00, 8'h00);
        step("sr_conf", 1, 0, 2'd3, 8'h81, 8'h01);
        check("sr_conf_q", {24'd0, q}, 32'h80);
        check("sr_conf_err", {31'd0, err}, 32'd1);
        step("sr_legal", 1, 0, 2'd3, 8'h02, 8'h80);
        check("sr_sticky", {31'd0, err}, 32'd1);
        step("sr_clr", 0, 1, 2'd3, 8'hFF, 8'hFF);
        check("sr_clr_q", {24'd0, q}, 32'h00);
        check("sr_clr_err", {31'd0, err}, 32'd0);

        step("hold_pre", 1, 0, 2'd0, 8'h69, 8'h00);
        step("hold", 0, 0, 2'd1, 8'hFF, 8'hFF);
        check("hold_const", {24'd0, q}, 32'h69);
        step("hold_sr", 0, 0, 2'd3, 8'hFF, 8'hFF);
        check("hold_no_err", {31'd0, err}, 32'd0);

        step("pri_pre", 1, 0, 2'd0, 8'h3C, 8'h00);
        step("pri_clr_en", 1, 1, 2'd0, 8'hFF, 8'h00);
        check("pri_q", {24'd0, q}, 32'h00);
        check("pri_chg", {31'd0, chg}, 32'd1);

        step("rst_pre", 1, 0, 2'd0, 8'h55, 8'h00);
        step("rst_err", 1, 0, 2'd3, 8'h01, 8'h01);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst_q", {24'd0, q}, 32'h00);
        @(negedge clk);
        rstn = 1'b1;

        for (int n = 0; n < 20; n++) begin
            step($sformatf("rand%0d", n), 1'($urandom_range(0, 3) != 0), 1'b0,
                 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
